// File: rtl/bist_pkg.sv
// Shared definitions for the March C- BIST controller: element table, op
// encoding and FSM states. Optional diagnostics are enabled by BIST_DIAG_EN.
package bist_pkg;

   localparam logic [2:0] M0 = 3'd0;
   localparam logic [2:0] M1 = 3'd1;
   localparam logic [2:0] M2 = 3'd2;
   localparam logic [2:0] M3 = 3'd3;
   localparam logic [2:0] M4 = 3'd4;
   localparam logic [2:0] M5 = 3'd5;
   localparam logic [2:0] MARCH_LAST = M5;

   typedef enum logic {OP_R = 1'b0, OP_W = 1'b1} op_e;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_e;

   typedef struct packed {
      logic down;
      logic two_ops;
      op_e  op0;
      logic val0;
      op_e  op1;
      logic val1;
   } elem_cfg_t;

   function automatic logic elem_is_down(input logic [2:0] e);
      return (e == M3) || (e == M4);
   endfunction

   function automatic elem_cfg_t elem_cfg(input logic [2:0] e);
      elem_cfg_t c;
      c.down = elem_is_down(e);
      case (e)
         M0:      begin c.two_ops = 1'b0; c.op0 = OP_W; c.val0 = 1'b0; c.op1 = OP_W; c.val1 = 1'b0; end
         M1, M3:  begin c.two_ops = 1'b1; c.op0 = OP_R; c.val0 = 1'b0; c.op1 = OP_W; c.val1 = 1'b1; end
         M2, M4:  begin c.two_ops = 1'b1; c.op0 = OP_R; c.val0 = 1'b1; c.op1 = OP_W; c.val1 = 1'b0; end
         default: begin c.two_ops = 1'b0; c.op0 = OP_R; c.val0 = 1'b0; c.op1 = OP_R; c.val1 = 1'b0; end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/bist_addr_gen.sv
// Up/down address counter for the March sequencer; load has priority over step
// and tc_o flags the last cell in the current direction.
module bist_addr_gen #(
   parameter int AWIDTH = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic              load_max_i,
   input  logic              step_i,
   input  logic              down_i,
   output logic [AWIDTH-1:0] addr_o,
   output logic              tc_o
);

   logic [AWIDTH-1:0] addr_q, addr_d;

   always_comb begin
      addr_d = addr_q;
      if (load_i)
         addr_d = load_max_i ? {AWIDTH{1'b1}} : {AWIDTH{1'b0}};
      else if (step_i)
         addr_d = down_i ? addr_q - AWIDTH'(1) : addr_q + AWIDTH'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) addr_q <= '0;
      else         addr_q <= addr_d;
   end

   assign addr_o = addr_q;
   assign tc_o   = down_i ? (addr_q == {AWIDTH{1'b0}}) : (addr_q == {AWIDTH{1'b1}});

endmodule

// File: rtl/march_bist_ctrl.sv
// March C- BIST controller: one RAM op per cycle, one-cycle delayed compare.
// Define BIST_DIAG_EN to build fail_elem/fail_addr/fail_cnt; otherwise they are 0.
module march_bist_ctrl
   import bist_pkg::*;
#(
   parameter int AWIDTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [AWIDTH-1:0] wr_addr,
   output logic [AWIDTH-1:0] rd_addr,
   output logic              data_in,
   output logic              we,
   output logic              re,
   input  logic              data_out,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [2:0]        fail_elem,
   output logic [AWIDTH-1:0] fail_addr,
   output logic [7:0]        fail_cnt
);

   state_e            state_q, state_d;
   logic [2:0]        elem_q, elem_d;
   logic              op_q, op_d;
   logic [AWIDTH-1:0] addr;
   logic              tc;
   logic              ag_load, ag_load_max, ag_step;
   elem_cfg_t         cfg;
   op_e               cur_op;
   logic              cur_val;
   logic              running, cell_done, last_op, start_ok;
   logic              cmp_vld_q, cmp_exp_q, mismatch;
   logic              mis_any_q, pass_q;

   assign cfg       = elem_cfg(elem_q);
   assign cur_op    = op_q ? cfg.op1  : cfg.op0;
   assign cur_val   = op_q ? cfg.val1 : cfg.val0;
   assign running   = (state_q == RUN);
   assign cell_done = !cfg.two_ops || op_q;
   assign last_op   = running && cell_done && tc && (elem_q == MARCH_LAST);
   assign start_ok  = start && ((state_q == IDLE) || (state_q == DONE));

   bist_addr_gen #(.AWIDTH(AWIDTH)) u_addr_gen (
      .clk_i      (clk),
      .rst_ni     (reset),
      .load_i     (ag_load),
      .load_max_i (ag_load_max),
      .step_i     (ag_step),
      .down_i     (cfg.down),
      .addr_o     (addr),
      .tc_o       (tc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)   state_d = RUN;
         RUN:     if (last_op) state_d = DRAIN;
         DRAIN:                state_d = DONE;
         DONE:    if (start)   state_d = RUN;
         default:              state_d = IDLE;
      endcase
   end

   always_comb begin
      we      = running && (cur_op == OP_W);
      re      = running && (cur_op == OP_R);
      wr_addr = we ? addr : '0;
      rd_addr = re ? addr : '0;
      data_in = we && cur_val;
      busy    = (state_q == RUN) || (state_q == DRAIN);
      done    = (state_q == DONE);
   end

   // Element/op/address sequencing; counters return to M0 @0 after the last op.
   always_comb begin
      elem_d      = elem_q;
      op_d        = op_q;
      ag_load     = 1'b0;
      ag_load_max = 1'b0;
      ag_step     = 1'b0;
      if (start_ok) begin
         elem_d  = M0;
         op_d    = 1'b0;
         ag_load = 1'b1;
      end else if (running) begin
         if (!cell_done) begin
            op_d = 1'b1;
         end else begin
            op_d = 1'b0;
            if (!tc) begin
               ag_step = 1'b1;
            end else if (elem_q == MARCH_LAST) begin
               elem_d  = M0;
               ag_load = 1'b1;
            end else begin
               elem_d      = elem_q + 3'd1;
               ag_load     = 1'b1;
               ag_load_max = elem_is_down(elem_q + 3'd1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         elem_q <= M0;
         op_q   <= 1'b0;
      end else begin
         elem_q <= elem_d;
         op_q   <= op_d;
      end
   end

   // RAM data_out lags re by one cycle, so the expected bit is staged to match.
   assign mismatch = cmp_vld_q && (data_out != cmp_exp_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmp_vld_q <= 1'b0;
         cmp_exp_q <= 1'b0;
         mis_any_q <= 1'b0;
         pass_q    <= 1'b0;
      end else begin
         cmp_vld_q <= re;
         if (re) cmp_exp_q <= cur_val;
         if (start_ok) begin
            mis_any_q <= 1'b0;
            pass_q    <= 1'b0;
         end else begin
            if (mismatch) mis_any_q <= 1'b1;
            if (state_q == DRAIN) pass_q <= !(mis_any_q || mismatch);
         end
      end
   end

   assign pass = pass_q;

`ifdef BIST_DIAG_EN
   logic [2:0]        cmp_elem_q, fail_elem_q;
   logic [AWIDTH-1:0] cmp_addr_q, fail_addr_q;
   logic [7:0]        fail_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmp_elem_q  <= '0;
         cmp_addr_q  <= '0;
         fail_elem_q <= '0;
         fail_addr_q <= '0;
         fail_cnt_q  <= '0;
      end else begin
         if (re) begin
            cmp_elem_q <= elem_q;
            cmp_addr_q <= addr;
         end
         if (start_ok) begin
            fail_elem_q <= '0;
            fail_addr_q <= '0;
            fail_cnt_q  <= '0;
         end else if (mismatch) begin
            if (!mis_any_q) begin
               fail_elem_q <= cmp_elem_q;
               fail_addr_q <= cmp_addr_q;
            end
            if (fail_cnt_q != 8'hFF) fail_cnt_q <= fail_cnt_q + 8'd1;
         end
      end
   end

   assign fail_elem = fail_elem_q;
   assign fail_addr = fail_addr_q;
   assign fail_cnt  = fail_cnt_q;
`else
   assign fail_elem = '0;
   assign fail_addr = '0;
   assign fail_cnt  = '0;
`endif

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Directed bench for march_bist_ctrl with a behavioural fault-injectable 16x1 RAM.
// Diag expectations follow BIST_DIAG_EN (zeros when it is undefined).
module tb_march_bist_ctrl;

`ifdef BIST_DIAG_EN
   localparam bit DIAG = 1'b1;
`else
   localparam bit DIAG = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [3:0] wr_addr, rd_addr, fail_addr;
   logic       data_in, we, re, busy, done, pass;
   logic [2:0] fail_elem;
   logic [7:0] fail_cnt;
   logic       dout;

   logic [15:0] mem;
   logic        pwrup = 1'b0;
   logic [1:0]  fault = 2'b11;

   int total = 0;
   int bad   = 0;

   logic [6:0] trace [160];
   logic       c0_done, c0_pass;
   logic [7:0] c0_cnt;

   logic [28:0] outs;
   assign outs = {we, re, data_in, busy, done, pass, wr_addr, rd_addr, fail_elem, fail_addr, fail_cnt};

   always #5 clk = ~clk;

   march_bist_ctrl #(.AWIDTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .wr_addr   (wr_addr),
      .rd_addr   (rd_addr),
      .data_in   (data_in),
      .we        (we),
      .re        (re),
      .data_out  (dout),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .fail_elem (fail_elem),
      .fail_addr (fail_addr),
      .fail_cnt  (fail_cnt)
   );

   // fault 00: @5 s-a-0, @11 s-a-1; 01: @8 no 0->1, @2 no 1->0; 10: @7 0->1 toggles @3
   function automatic logic wbit(input logic [1:0] f, input logic [3:0] a, input logic d, input logic cur);
      if (f == 2'b01 && a == 4'd8 && !cur && d) return 1'b0;
      if (f == 2'b01 && a == 4'd2 && cur && !d) return 1'b1;
      return d;
   endfunction

   function automatic logic rbit(input logic [1:0] f, input logic [3:0] a, input logic [15:0] m);
      if (f == 2'b00 && a == 4'd5)  return 1'b0;
      if (f == 2'b00 && a == 4'd11) return 1'b1;
      return m[a];
   endfunction

   always @(posedge clk) begin
      if (pwrup) mem <= '1;
      else if (we) begin
         mem[wr_addr] <= wbit(fault, wr_addr, data_in, mem[wr_addr]);
         if (fault == 2'b10 && wr_addr == 4'd7 && !mem[7] && data_in) mem[3] <= ~mem[3];
      end
      if (re) dout <= rbit(fault, rd_addr, mem);
   end

   task automatic run_bist(input logic [1:0] f, input bit poke, output int cyc, output int ops, output int both);
      fault = f;
      pwrup = 1'b1;
      @(negedge clk);
      pwrup = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0; ops = 0; both = 0;
      c0_done = done; c0_pass = pass; c0_cnt = fail_cnt;
      while (!done && cyc < 400) begin
         if (we || re) ops++;
         if (we && re) both++;
         if (cyc < 160) trace[cyc] = {we, re, data_in, (we ? wr_addr : rd_addr)};
         start = poke && (cyc == 5 || cyc == 80 || cyc == 160);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      total++;
      if (!done) begin
         bad++;
         $display("FAIL run_timeout: done=%0b after %0d cycles, expected done by 161", done, cyc);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #3 reset = 1'b0;
      #10;
      total++;
      if (outs !== 29'd0) begin
         bad++;
         $display("FAIL reset_outputs: got %h expected 0", outs);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      total++;
      if ({busy, done, we, re} !== 4'b0000) begin
         bad++;
         $display("FAIL idle_after_reset: busy/done/we/re=%b expected 0000", {busy, done, we, re});
      end
   endtask

   task automatic test_fault_free();
      int cyc, ops, both;
      int         idx [10]    = '{0, 16, 17, 47, 48, 80, 81, 82, 143, 159};
      logic [6:0] exp_tr [10] = '{7'b1000000, 7'b0100000, 7'b1010000, 7'b1011111, 7'b0100000,
                                  7'b0101111, 7'b1011111, 7'b0101110, 7'b1000000, 7'b0101111};
      run_bist(2'b11, 1'b0, cyc, ops, both);
      total++;
      if (cyc !== 161) begin bad++; $display("FAIL ff_done_latency: got %0d expected 161", cyc); end
      total++;
      if (ops !== 160) begin bad++; $display("FAIL ff_op_count: got %0d expected 160", ops); end
      total++;
      if (both !== 0) begin bad++; $display("FAIL ff_we_re_overlap: got %0d expected 0", both); end
      total++;
      if (pass !== 1'b1) begin bad++; $display("FAIL ff_pass: got %b expected 1", pass); end
      total++;
      if ({fail_elem, fail_addr, fail_cnt} !== 15'd0) begin
         bad++; $display("FAIL ff_diag: got %h expected 0", {fail_elem, fail_addr, fail_cnt});
      end
      for (int i = 0; i < 10; i++) begin
         total++;
         if (trace[idx[i]] !== exp_tr[i]) begin
            bad++;
            $display("FAIL ff_trace_op%0d: got %b expected %b", idx[i], trace[idx[i]], exp_tr[i]);
         end
      end
   endtask

   task automatic check_fault(input string nm, input logic [1:0] f, input logic [2:0] e_elem,
                              input logic [3:0] e_addr, input logic [7:0] e_cnt);
      int cyc, ops, both;
      logic [14:0] exp_diag;
      run_bist(f, 1'b0, cyc, ops, both);
      exp_diag = DIAG ? {e_elem, e_addr, e_cnt} : 15'd0;
      total++;
      if (pass !== 1'b0) begin bad++; $display("FAIL %s_pass: got %b expected 0", nm, pass); end
      total++;
      if (cyc !== 161) begin bad++; $display("FAIL %s_latency: got %0d expected 161", nm, cyc); end
      total++;
      if (both !== 0) begin bad++; $display("FAIL %s_we_re_overlap: got %0d expected 0", nm, both); end
      total++;
      if ({fail_elem, fail_addr, fail_cnt} !== exp_diag) begin
         bad++;
         $display("FAIL %s_diag: elem/addr/cnt got %0d/%0d/%0d expected %0d/%0d/%0d", nm,
                  fail_elem, fail_addr, fail_cnt, exp_diag[14:12], exp_diag[11:8], exp_diag[7:0]);
      end
   endtask

   task automatic test_stuck_at();
      check_fault("saf", 2'b00, 3'd1, 4'd11, 8'd5);
   endtask

   task automatic test_transition();
      check_fault("tf", 2'b01, 3'd1, 4'd2, 8'd5);
   endtask

   task automatic test_coupling();
      check_fault("cf", 2'b10, 3'd2, 4'd3, 8'd2);
   endtask

   task automatic test_reset_midrun();
      int cyc, ops, both;
      fault = 2'b11;
      pwrup = 1'b1;
      @(negedge clk);
      pwrup = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 70; i++) @(negedge clk);
      reset = 1'b0;
      #1;
      total++;
      if (outs !== 29'd0) begin bad++; $display("FAIL midrun_reset_now: got %h expected 0", outs); end
      @(negedge clk);
      total++;
      if (outs !== 29'd0) begin bad++; $display("FAIL midrun_reset_held: got %h expected 0", outs); end
      reset = 1'b1;
      @(negedge clk);
      total++;
      if ({busy, done} !== 2'b00) begin bad++; $display("FAIL midrun_idle: busy/done=%b expected 00", {busy, done}); end
      run_bist(2'b11, 1'b0, cyc, ops, both);
      total++;
      if ({pass, 9'(cyc)} !== {1'b1, 9'd161}) begin
         bad++; $display("FAIL midrun_rerun: pass=%b cyc=%0d expected pass=1 cyc=161", pass, cyc);
      end
   endtask

   task automatic test_start_ignored();
      int cyc, ops, both;
      run_bist(2'b11, 1'b1, cyc, ops, both);
      total++;
      if (cyc !== 161) begin bad++; $display("FAIL poke_latency: got %0d expected 161", cyc); end
      total++;
      if (ops !== 160) begin bad++; $display("FAIL poke_op_count: got %0d expected 160", ops); end
      total++;
      if (pass !== 1'b1) begin bad++; $display("FAIL poke_pass: got %b expected 1", pass); end
   endtask

   task automatic test_back_to_back();
      int cyc, ops, both;
      run_bist(2'b00, 1'b0, cyc, ops, both);
      run_bist(2'b11, 1'b0, cyc, ops, both);
      total++;
      if ({c0_done, c0_pass, c0_cnt} !== 10'd0) begin
         bad++; $display("FAIL b2b_clear: done/pass/cnt got %b/%b/%0d expected 0/0/0", c0_done, c0_pass, c0_cnt);
      end
      total++;
      if (cyc !== 161) begin bad++; $display("FAIL b2b_latency: got %0d expected 161", cyc); end
      total++;
      if ({pass, fail_elem, fail_addr, fail_cnt} !== {1'b1, 15'd0}) begin
         bad++; $display("FAIL b2b_result: pass=%b cnt=%0d expected pass=1 cnt=0", pass, fail_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_fault_free();
      test_stuck_at();
      test_transition();
      test_coupling();
      test_reset_midrun();
      test_start_ignored();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
